// File: rtl/delay_tap_ctrl.sv
// Tap-select controller for the four-tap 8-bit delay line: owns the output mux select,
// accepts tap changes over req/ack, counts fill since reset/flush and flags valid output.
module delay_tap_ctrl #(
    parameter int D0        = 30,
    parameter int D1        = 45,
    parameter int D2        = 60,
    parameter int D3        = 90,
    parameter int GUARD_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       flush,
    input  logic       sel_req,
    input  logic [1:0] sel_code,
    output logic       sel_ack,
    output logic [1:0] tap_sel,
    output logic       out_valid,
    output logic [6:0] fill_cnt
);

    localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

    localparam logic [6:0]    D0_W    = 7'(D0);
    localparam logic [6:0]    D1_W    = 7'(D1);
    localparam logic [6:0]    D2_W    = 7'(D2);
    localparam logic [6:0]    D3_W    = 7'(D3);
    localparam logic [GW-1:0] GC_LAST = GW'(GUARD_CYC - 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          armed;
    logic [GW-1:0] guard_cnt;
    logic [GW-1:0] guard_nxt;
    logic [6:0]    fill_nxt;
    logic [6:0]    tap_delay;
    logic          accept;
    logic          tap_change;

    // A request is taken once per assertion: armed re-arms only while sel_req is low,
    // and the pending ack blocks a back-to-back accept.
    assign accept     = sel_req & armed & ena & ~sel_ack;
    assign tap_change = accept && (sel_code != tap_sel);

    always_comb begin
        unique case (tap_sel)
            2'd0:    tap_delay = D0_W;
            2'd1:    tap_delay = D1_W;
            2'd2:    tap_delay = D2_W;
            default: tap_delay = D3_W;
        endcase
    end

    always_comb begin
        if (flush)
            fill_nxt = '0;
        else if (fill_cnt >= D3_W)
            fill_nxt = D3_W;
        else
            fill_nxt = fill_cnt + 7'd1;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        guard_nxt = guard_cnt;
        if (tap_change) begin
            state_nxt = GUARD;
            guard_nxt = GC_LAST;
        end else begin
            unique case (state)
                FILL: begin
                    if (fill_nxt >= tap_delay)
                        state_nxt = RUN;
                end
                RUN: begin
                    if (flush)
                        state_nxt = FILL;
                end
                GUARD: begin
                    // Flushes during the guard are absorbed here: fill_nxt is then 0.
                    if (guard_cnt == '0)
                        state_nxt = (fill_nxt >= tap_delay) ? RUN : FILL;
                    else
                        guard_nxt = guard_cnt - GW'(1);
                end
                default: state_nxt = FILL;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            guard_cnt <= '0;
            armed     <= 1'b1;
            tap_sel   <= 2'd0;
            sel_ack   <= 1'b0;
            out_valid <= 1'b0;
            fill_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            guard_cnt <= guard_nxt;
            fill_cnt  <= fill_nxt;
            sel_ack   <= accept;
            if (accept)
                tap_sel <= sel_code;
            if (accept)
                armed <= 1'b0;
            else if (!sel_req)
                armed <= 1'b1;
            out_valid <= ena && (state_nxt == RUN);
        end
    end

endmodule

// File: tb/tb_delay_tap_ctrl.sv
// Bench for delay_tap_ctrl: directed scenarios plus a random requester, all checked
// against a fill/guard-window reference model.
module tb_delay_tap_ctrl;

    localparam int D[4]      = '{30, 45, 60, 90};
    localparam int GUARD_CYC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b0;
    logic       flush = 1'b0;
    logic       sel_req = 1'b0;
    logic [1:0] sel_code = 2'd0;
    logic       sel_ack;
    logic [1:0] tap_sel;
    logic       out_valid;
    logic [6:0] fill_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: valid whenever the guard window has elapsed and enough samples
    // have entered the line for the selected tap.
    int         m_fill;
    int         m_edge = 0;
    int         m_guard_until;
    logic [1:0] m_tap;
    logic       m_ack;
    logic       m_armed;
    logic       m_valid;

    delay_tap_ctrl #(
        .D0(D[0]), .D1(D[1]), .D2(D[2]), .D3(D[3]), .GUARD_CYC(GUARD_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .flush(flush),
        .sel_req(sel_req), .sel_code(sel_code), .sel_ack(sel_ack),
        .tap_sel(tap_sel), .out_valid(out_valid), .fill_cnt(fill_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_fill        = 0;
        m_tap         = 2'd0;
        m_ack         = 1'b0;
        m_armed       = 1'b1;
        m_valid       = 1'b0;
        m_guard_until = -1000;
    endtask

    // Advance one clock edge in both DUT and model; returns at the following negedge.
    task automatic step();
        bit acc;
        @(posedge clk);
        acc = sel_req && m_armed && ena && !m_ack;
        if (flush)
            m_fill = 0;
        else if (m_fill + 1 > D[3])
            m_fill = D[3];
        else
            m_fill = m_fill + 1;
        if (acc && sel_code != m_tap)
            m_guard_until = m_edge + GUARD_CYC;
        if (acc)
            m_tap = sel_code;
        if (acc)
            m_armed = 1'b0;
        else if (!sel_req)
            m_armed = 1'b1;
        m_ack   = acc;
        m_valid = ena && (m_edge >= m_guard_until) && (m_fill >= D[m_tap]);
        m_edge++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if ({tap_sel, sel_ack, out_valid, fill_cnt} !== 11'd0) begin
            n_err++;
            $display("FAIL reset: got tap=%0d ack=%b valid=%b fill=%0d, want all 0",
                     tap_sel, sel_ack, out_valid, fill_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ena   = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 95; i++) begin
            step();
            n_cmp++;
            if ({tap_sel, sel_ack, out_valid, fill_cnt} !== {m_tap, m_ack, m_valid, 7'(m_fill)}) begin
                n_err++;
                $display("FAIL fill edge %0d: got tap=%0d ack=%b valid=%b fill=%0d, want tap=%0d ack=%b valid=%b fill=%0d",
                         i, tap_sel, sel_ack, out_valid, fill_cnt, m_tap, m_ack, m_valid, m_fill);
            end
            if (i == 29 || i == 30 || i == 90 || i == 95) begin
                n_cmp++;
                if (out_valid !== (i >= 30) || fill_cnt !== 7'((i > 90) ? 90 : i)) begin
                    n_err++;
                    $display("FAIL fill_mark edge %0d: got valid=%b fill=%0d, want valid=%b fill=%0d",
                             i, out_valid, fill_cnt, (i >= 30), (i > 90) ? 90 : i);
                end
            end
        end
    endtask

    // Raise sel_req with a code, hold until the model acks (bounded), then drop it.
    task automatic test_request(input logic [1:0] code, input int tail, input string name);
        int acks = 0;
        int lows = 0;
        sel_req  = 1'b1;
        sel_code = code;
        for (int i = 0; i < tail + 1; i++) begin
            step();
            if (sel_ack === 1'b1) acks++;
            if (sel_ack === 1'b1 || i > 3) sel_req = 1'b0;
            if (out_valid === 1'b0) lows++;
            n_cmp++;
            if ({tap_sel, sel_ack, out_valid, fill_cnt} !== {m_tap, m_ack, m_valid, 7'(m_fill)}) begin
                n_err++;
                $display("FAIL %s cyc %0d: got tap=%0d ack=%b valid=%b fill=%0d, want tap=%0d ack=%b valid=%b fill=%0d",
                         name, i, tap_sel, sel_ack, out_valid, fill_cnt, m_tap, m_ack, m_valid, m_fill);
            end
        end
        n_cmp++;
        if (acks !== 1) begin
            n_err++;
            $display("FAIL %s ack_count: got %0d, want 1", name, acks);
        end
    endtask

    task automatic test_saturated_change();
        test_request(2'd3, 8, "sat_change");
        n_cmp++;
        if (tap_sel !== 2'd3 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL sat_change_end: got tap=%0d valid=%b, want tap=3 valid=1", tap_sel, out_valid);
        end
    endtask

    task automatic test_change_mid_fill();
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 40; i++) step();
        n_cmp++;
        if (fill_cnt !== 7'd40 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_fill_pre: got fill=%0d valid=%b, want fill=40 valid=0", fill_cnt, out_valid);
        end
        test_request(2'd2, 25, "mid_fill");
    endtask

    task automatic test_flush_run();
        test_request(2'd1, 12, "to_tap1");
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++;
        if (fill_cnt !== 7'd0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_run: got fill=%0d valid=%b, want fill=0 valid=0", fill_cnt, out_valid);
        end
        for (int i = 1; i <= 50; i++) begin
            step();
            n_cmp++;
            if ({tap_sel, out_valid, fill_cnt} !== {m_tap, m_valid, 7'(m_fill)} ||
                out_valid !== (i >= 45)) begin
                n_err++;
                $display("FAIL flush_refill edge %0d: got valid=%b fill=%0d, want valid=%b fill=%0d",
                         i, out_valid, fill_cnt, m_valid, m_fill);
            end
        end
    endtask

    task automatic test_ena_hold();
        int acks = 0;
        ena      = 1'b0;
        sel_req  = 1'b1;
        sel_code = 2'd0;
        for (int i = 0; i < 30; i++) begin
            if (i == 5) ena = 1'b1;
            if (i == 16) sel_req = 1'b0;
            if (i == 17) sel_req = 1'b1;
            if (i == 20) sel_req = 1'b0;
            step();
            if (sel_ack === 1'b1) acks++;
            n_cmp++;
            if ({tap_sel, sel_ack, out_valid, fill_cnt} !== {m_tap, m_ack, m_valid, 7'(m_fill)} ||
                (i < 5 && sel_ack !== 1'b0) || (i == 5 && sel_ack !== 1'b1)) begin
                n_err++;
                $display("FAIL ena_hold cyc %0d: got tap=%0d ack=%b valid=%b fill=%0d, want tap=%0d ack=%b valid=%b fill=%0d",
                         i, tap_sel, sel_ack, out_valid, fill_cnt, m_tap, m_ack, m_valid, m_fill);
            end
        end
        n_cmp++;
        if (acks !== 2) begin
            n_err++;
            $display("FAIL ena_hold ack_count: got %0d, want 2", acks);
        end
    endtask

    task automatic test_reset_mid_guard();
        int waited = 0;
        sel_req  = 1'b1;
        sel_code = (m_tap == 2'd2) ? 2'd1 : 2'd2;
        while (!m_ack && waited < 10) begin
            step();
            waited++;
        end
        n_cmp++;
        if (sel_ack !== 1'b1 || fill_cnt === 7'd0 || tap_sel === 2'd0) begin
            n_err++;
            $display("FAIL guard_setup: got ack=%b tap=%0d fill=%0d, want ack=1 nonzero tap and fill",
                     sel_ack, tap_sel, fill_cnt);
        end
        sel_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({tap_sel, sel_ack, out_valid, fill_cnt} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_mid_guard: got tap=%0d ack=%b valid=%b fill=%0d, want all 0",
                     tap_sel, sel_ack, out_valid, fill_cnt);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            ena   = ($urandom_range(0, 15) != 0);
            flush = ($urandom_range(0, 99) == 0);
            if (!sel_req) begin
                if ($urandom_range(0, 19) == 0) begin
                    sel_req  = 1'b1;
                    sel_code = 2'($urandom_range(0, 3));
                end
            end else if (m_ack && $urandom_range(0, 3) != 0) begin
                sel_req = 1'b0;
            end
            step();
            n_cmp++;
            if ({tap_sel, sel_ack, out_valid, fill_cnt} !== {m_tap, m_ack, m_valid, 7'(m_fill)}) begin
                n_err++;
                $display("FAIL random cyc %0d: got tap=%0d ack=%b valid=%b fill=%0d, want tap=%0d ack=%b valid=%b fill=%0d",
                         i, tap_sel, sel_ack, out_valid, fill_cnt, m_tap, m_ack, m_valid, m_fill);
            end
        end
        sel_req = 1'b0;
        flush   = 1'b0;
        ena     = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_saturated_change();
        test_change_mid_fill();
        test_flush_run();
        test_ena_hold();
        test_reset_mid_guard();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
